instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h00000000, the PC value loaded on reset.
REQ-002 The module SHALL have parameter IMEM_BYTES, default 1024, the instruction memory size in bytes; fetch addresses >= IMEM_BYTES are out of range.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 imem_addr  output  32  byte address presented to instruction memory; equals the PC register.
REQ-006 imem_instr  input  32  instruction word returned combinationally by memory for imem_addr in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump redirect request, one-cycle qualifier.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-010 out_ready  input  1  consumer accepts the instruction when out_valid && out_ready.
REQ-011 out_instr  output  32  registered fetched instruction.
REQ-012 out_pc  output  32  registered address of out_instr.
REQ-013 fault  output  1  sticky fetch fault indicator.

Function
REQ-014 The state machine SHALL have two states: RUN and FAULT.
REQ-015 In RUN, "slot free" SHALL mean !out_valid || out_ready.
REQ-016 In RUN, with no redirect, pc in range and slot free: capture out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+4.
REQ-017 In RUN, with no redirect and slot not free: pc, out_instr, out_pc and out_valid SHALL hold (stall); imem_addr stays stable.
REQ-018 If out_valid && out_ready and no new capture occurs, out_valid SHALL drop to 0 on the next edge.
REQ-019 Fetch latency: the instruction at address A SHALL appear on out_* on the edge after imem_addr==A with slot free.
REQ-020 redirect_valid SHALL take priority over fetch and stall: pc<=redirect_pc, out_valid<=0 (flush), no capture that cycle, regardless of out_ready.
REQ-021 A redirect with redirect_pc[1:0]!=0 SHALL move to FAULT: fault<=1, out_valid<=0, pc<=redirect_pc.
REQ-022 In RUN, with no redirect and pc >= IMEM_BYTES: move to FAULT, fault<=1, out_valid<=0, no capture.
REQ-023 Out-of-range detection SHALL occur when the PC is presented, not when it is incremented; pc+4 wraps modulo 2^32 without a separate flag.
REQ-024 FAULT SHALL be absorbing: pc, out_valid=0 and fault=1 hold, and redirects are ignored until reset.
REQ-025 pc SHALL always be word-aligned in RUN.

Reset
REQ-026 When rst_n=0 at a rising edge, the module SHALL set pc<=RESET_PC, out_valid<=0, out_instr<=0, out_pc<=0, fault<=0, state<=RUN.
REQ-027 Reset SHALL override redirect, stall and FAULT; reset mid-stall SHALL discard the held instruction.
REQ-028 The first capture SHALL occur on the first edge with rst_n=1, using the instruction at address RESET_PC.

Verification
REQ-029 Streaming: reset, out_ready=1, memory word at 0x0/0x4/0x8 = 0x00500093/0x00300113/0x002081B3 -> out_valid=1 on edges 1-3 with out_pc 0x0, 0x4, 0x8 and matching out_instr; imem_addr 0x4, 0x8, 0xC.
REQ-030 Stall: out_ready=0 after the first capture for 3 cycles -> out_pc=0x0 and imem_addr=0x4 hold; after out_ready=1, next out_pc=0x4 with no skip or duplicate.
REQ-031 Redirect: redirect_valid=1, redirect_pc=0x20 while out_valid=1 and out_ready=0 -> next edge out_valid=0, imem_addr=0x20; following edge out_pc=0x20.
REQ-032 Faults: (a) redirect_pc=0x22 -> fault=1, out_valid=0, and a later redirect to 0x0 is ignored; (b) IMEM_BYTES=16, streaming from 0x0 -> out_pc 0x0-0xC delivered, then fault=1 with imem_addr=0x10.
REQ-033 Reset recovery: assert rst_n=0 for one edge while in FAULT or stalled -> fault=0, out_valid=0, imem_addr=RESET_PC; streaming resumes per REQ-029.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: presents the PC to instruction memory, registers the
// returned word into a single-entry output slot with a valid/ready handshake,
// and handles redirects plus sticky faults for misaligned or out-of-range fetches.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        fault_o
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_e;

  localparam logic [31:0] ImemLimit = 32'(IMEM_BYTES);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        fault_q, fault_d;

  logic        slot_free;
  logic        pc_out_of_range;
  logic        redirect_misaligned;

  assign slot_free           = !out_valid_q || out_ready_i;
  assign pc_out_of_range     = (pc_q >= ImemLimit);
  assign redirect_misaligned = (redirect_pc_i[1:0] != 2'b00);

  // State register; reset wins over everything, including a pending fault or stall.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_pc_q    <= 32'h0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state logic: redirect beats fetch/stall, range check is done on the
  // presented PC (the +4 itself simply wraps), and FAULT holds until reset.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    fault_d     = fault_q;

    unique case (state_q)
      RUN: begin
        if (redirect_valid_i) begin
          pc_d        = redirect_pc_i;
          out_valid_d = 1'b0;
          if (redirect_misaligned) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end
        end else if (pc_out_of_range) begin
          state_d     = FAULT;
          fault_d     = 1'b1;
          out_valid_d = 1'b0;
        end else if (slot_free) begin
          out_instr_d = imem_instr_i;
          out_pc_d    = pc_q;
          out_valid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
        end
      end
      FAULT: begin
        out_valid_d = 1'b0;
        fault_d     = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign imem_addr_o = pc_q;
  assign out_valid_o = out_valid_q;
  assign out_instr_o = out_instr_q;
  assign out_pc_o    = out_pc_q;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stall, redirect, faults and
// reset recovery on a default-size instance plus a 16-byte memory instance.
module tb_instr_fetch_unit;

  logic        clk;
  int          checkCount;
  int          errorCount;

  // Signals for the default-parameter instance
  logic        rstN;
  logic [31:0] imemAddr;
  logic [31:0] imemInstr;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInstr;
  logic [31:0] outPc;
  logic        fault;

  // Signals for the 16-byte memory instance
  logic        rstN2;
  logic [31:0] imemAddr2;
  logic [31:0] imemInstr2;
  logic        outValid2;
  logic [31:0] outInstr2;
  logic [31:0] outPc2;
  logic        fault2;

  instr_fetch_unit dut (
    .clk_i            (clk),
    .rst_ni           (rstN),
    .imem_addr_o      (imemAddr),
    .imem_instr_i     (imemInstr),
    .redirect_valid_i (redirectValid),
    .redirect_pc_i    (redirectPc),
    .out_valid_o      (outValid),
    .out_ready_i      (outReady),
    .out_instr_o      (outInstr),
    .out_pc_o         (outPc),
    .fault_o          (fault)
  );

  instr_fetch_unit #(.IMEM_BYTES(16)) dutSmall (
    .clk_i            (clk),
    .rst_ni           (rstN2),
    .imem_addr_o      (imemAddr2),
    .imem_instr_i     (imemInstr2),
    .redirect_valid_i (1'b0),
    .redirect_pc_i    (32'h0),
    .out_valid_o      (outValid2),
    .out_ready_i      (1'b1),
    .out_instr_o      (outInstr2),
    .out_pc_o         (outPc2),
    .fault_o          (fault2)
  );

  // Memory contents: three real instructions at the bottom, tagged filler elsewhere.
  function automatic logic [31:0] memWord(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00300113;
      32'h8:   return 32'h002081B3;
      default: return {16'hC0DE, addr[15:0]};
    endcase
  endfunction

  // Combinational memory read for both instances
  always_comb begin
    imemInstr  = memWord(imemAddr);
    imemInstr2 = memWord(imemAddr2);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkSlot(input string tag, input logic valid,
                           input logic [31:0] pc, input logic [31:0] instr,
                           input logic [31:0] addr);
    checkOutput({tag, ".valid"}, {31'h0, outValid}, {31'h0, valid});
    checkOutput({tag, ".pc"},    outPc,    pc);
    checkOutput({tag, ".instr"}, outInstr, instr);
    checkOutput({tag, ".addr"},  imemAddr, addr);
  endtask

  initial begin
    checkCount    = 0;
    errorCount    = 0;
    rstN          = 1'b0;
    rstN2         = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;
    outReady      = 1'b1;

    // Reset state
    applyStimulus();
    checkSlot("reset", 1'b0, 32'h0, 32'h0, 32'h0);
    checkOutput("reset.fault", {31'h0, fault}, 32'h0);

    // Streaming from address 0
    rstN = 1'b1;
    applyStimulus();
    checkSlot("stream0", 1'b1, 32'h0, 32'h00500093, 32'h4);
    applyStimulus();
    checkSlot("stream1", 1'b1, 32'h4, 32'h00300113, 32'h8);
    applyStimulus();
    checkSlot("stream2", 1'b1, 32'h8, 32'h002081B3, 32'hC);

    // Stall after the first capture, then release
    rstN = 1'b0;
    applyStimulus();
    rstN = 1'b1;
    applyStimulus();
    checkSlot("stallCap", 1'b1, 32'h0, 32'h00500093, 32'h4);
    outReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkSlot("stallHold", 1'b1, 32'h0, 32'h00500093, 32'h4);
    end
    outReady = 1'b1;
    applyStimulus();
    checkSlot("stallRelease", 1'b1, 32'h4, 32'h00300113, 32'h8);

    // Redirect while the slot is full and the consumer is stalled
    outReady = 1'b0;
    applyStimulus();
    checkSlot("preRedirect", 1'b1, 32'h4, 32'h00300113, 32'h8);
    redirectValid = 1'b1;
    redirectPc    = 32'h20;
    applyStimulus();
    checkOutput("redirect.valid", {31'h0, outValid}, 32'h0);
    checkOutput("redirect.addr", imemAddr, 32'h20);
    redirectValid = 1'b0;
    outReady      = 1'b1;
    applyStimulus();
    checkSlot("redirectFetch", 1'b1, 32'h20, 32'hC0DE0020, 32'h24);

    // Misaligned redirect faults; a later redirect is ignored
    redirectValid = 1'b1;
    redirectPc    = 32'h22;
    applyStimulus();
    checkOutput("misalign.fault", {31'h0, fault}, 32'h1);
    checkOutput("misalign.valid", {31'h0, outValid}, 32'h0);
    checkOutput("misalign.addr", imemAddr, 32'h22);
    redirectPc = 32'h0;
    applyStimulus();
    checkOutput("faultSticky.fault", {31'h0, fault}, 32'h1);
    checkOutput("faultSticky.valid", {31'h0, outValid}, 32'h0);
    checkOutput("faultSticky.addr", imemAddr, 32'h22);
    redirectValid = 1'b0;

    // Reset recovery out of FAULT
    rstN = 1'b0;
    applyStimulus();
    checkOutput("faultReset.fault", {31'h0, fault}, 32'h0);
    checkSlot("faultReset", 1'b0, 32'h0, 32'h0, 32'h0);
    rstN = 1'b1;
    applyStimulus();
    checkSlot("recover0", 1'b1, 32'h0, 32'h00500093, 32'h4);
    applyStimulus();
    checkSlot("recover1", 1'b1, 32'h4, 32'h00300113, 32'h8);

    // Reset in the middle of a stall discards the held word
    outReady = 1'b0;
    applyStimulus();
    checkSlot("midStall", 1'b1, 32'h4, 32'h00300113, 32'h8);
    rstN = 1'b0;
    applyStimulus();
    checkSlot("stallReset", 1'b0, 32'h0, 32'h0, 32'h0);
    rstN     = 1'b1;
    outReady = 1'b1;
    applyStimulus();
    checkSlot("stallRecover", 1'b1, 32'h0, 32'h00500093, 32'h4);

    // Reset overrides a simultaneous redirect
    rstN          = 1'b0;
    redirectValid = 1'b1;
    redirectPc    = 32'h40;
    applyStimulus();
    checkOutput("resetVsRedirect.addr", imemAddr, 32'h0);
    checkOutput("resetVsRedirect.fault", {31'h0, fault}, 32'h0);
    rstN = 1'b1;

    // Last in-range word then out-of-range fault at the 1024-byte boundary
    redirectPc = 32'h3FC;
    applyStimulus();
    checkOutput("edge.addr", imemAddr, 32'h3FC);
    redirectValid = 1'b0;
    applyStimulus();
    checkSlot("edgeFetch", 1'b1, 32'h3FC, 32'hC0DE03FC, 32'h400);
    applyStimulus();
    checkOutput("range.fault", {31'h0, fault}, 32'h1);
    checkOutput("range.valid", {31'h0, outValid}, 32'h0);
    checkOutput("range.addr", imemAddr, 32'h400);

    // 16-byte memory: four words delivered, then fault at 0x10
    applyStimulus();
    rstN2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("small.valid", {31'h0, outValid2}, 32'h1);
      checkOutput("small.pc", outPc2, 32'(i * 4));
      checkOutput("small.instr", outInstr2, memWord(32'(i * 4)));
      checkOutput("small.fault", {31'h0, fault2}, 32'h0);
    end
    applyStimulus();
    checkOutput("smallFault.fault", {31'h0, fault2}, 32'h1);
    checkOutput("smallFault.valid", {31'h0, outValid2}, 32'h0);
    checkOutput("smallFault.addr", imemAddr2, 32'h10);
    applyStimulus();
    checkOutput("smallHold.fault", {31'h0, fault2}, 32'h1);
    checkOutput("smallHold.addr", imemAddr2, 32'h10);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
